// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and sizing for the RV32I data-memory path.
// Holds the arbiter FSM state encoding, the requester (owner) encoding,
// the DM/register sizing constants and the round-robin pick helper.
package rv32i_pkg;

    localparam int DM_AW = 5;
    localparam int XLEN  = 32;

    // Width of the consecutive-locked-grant counter used by the dbg lock.
    localparam int LOCK_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } owner_e;

    // Round-robin choice between two requesters: a lone requester wins,
    // a tie goes to the port that was not granted last.
    function automatic owner_e rr_pick(input logic core_v, input logic dbg_v,
                                       input owner_e last);
        owner_e pick;
        if (core_v && dbg_v) begin
            if (last == DBG) begin
                pick = CORE;
            end else begin
                pick = DBG;
            end
        end else if (core_v) begin
            pick = CORE;
        end else begin
            pick = DBG;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rv32i_rr_arb2.sv
// rv32i_rr_arb2: two-input round-robin grant with a last_grant register.
// lock_i forces the grant to the dbg input (core is blocked even when
// it is the only requester); last_grant advances only on an accepted grant.
module rv32i_rr_arb2
    import rv32i_pkg::*;
(
    input  logic   clk,
    input  logic   rn_i,
    input  logic   req_core_i,
    input  logic   req_dbg_i,
    input  logic   lock_i,
    input  logic   accept_i,
    output logic   gnt_valid_o,
    output owner_e gnt_owner_o,
    output owner_e last_grant_o
);

    owner_e last_grant_q;

    // Select the winner for this cycle from the current requests.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_owner_o = CORE;
        if (lock_i) begin
            gnt_valid_o = req_dbg_i;
            gnt_owner_o = DBG;
        end else begin
            gnt_valid_o = req_core_i | req_dbg_i;
            gnt_owner_o = rr_pick(req_core_i, req_dbg_i, last_grant_q);
        end
    end

    // Remember the last accepted winner; reset favours the core on the first tie.
    always_ff @(posedge clk) begin
        if (!rn_i) begin
            last_grant_q <= DBG;
        end else if (accept_i) begin
            last_grant_q <= gnt_owner_o;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end

    assign last_grant_o = last_grant_q;

endmodule

// File: rtl/rv32i_dmem_arbiter.sv
// rv32i_dmem_arbiter: shares the single-port DM between the core MEM stage
// and a debug/loader port. IDLE -> ISSUE -> (WAIT for reads) -> RESP -> IDLE.
// Optional feature macro: RV32I_DMEM_ARB_LOCK_EN (dbg grant lock, bounded
// to 8 consecutive locked grants). Without it dbg_req_lock is ignored.
module rv32i_dmem_arbiter
    import rv32i_pkg::*;
#(
    parameter int AW     = DM_AW,
    parameter int DW     = XLEN,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          core_req_valid,
    output logic          core_req_ready,
    input  logic          core_req_we,
    input  logic [AW-1:0] core_req_addr,
    input  logic [DW-1:0] core_req_wdata,
    output logic          core_rsp_valid,
    output logic [DW-1:0] core_rsp_rdata,
    input  logic          dbg_req_valid,
    output logic          dbg_req_ready,
    input  logic          dbg_req_we,
    input  logic [AW-1:0] dbg_req_addr,
    input  logic [DW-1:0] dbg_req_wdata,
    output logic          dbg_rsp_valid,
    output logic [DW-1:0] dbg_rsp_rdata,
    input  logic          dbg_req_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e    state_q;
    owner_e        owner_q;
    logic          cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic [2:0]    lat_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          busy_q;
    logic          core_rsp_valid_q;
    logic          dbg_rsp_valid_q;
    logic [DW-1:0] core_rsp_rdata_q;
    logic [DW-1:0] dbg_rsp_rdata_q;

    logic          idle_s;
    logic          gnt_valid_s;
    owner_e        gnt_owner_s;
    owner_e        last_grant_s;
    logic          accept_s;
    logic          lock_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    // Ready is only offered in IDLE and never while reset is asserted.
    assign idle_s   = (state_q == IDLE) && RN;
    assign accept_s = idle_s && gnt_valid_s;

    rv32i_rr_arb2 u_arb (
        .clk          (clk),
        .rn_i         (RN),
        .req_core_i   (core_req_valid),
        .req_dbg_i    (dbg_req_valid),
        .lock_i       (lock_s),
        .accept_i     (accept_s),
        .gnt_valid_o  (gnt_valid_s),
        .gnt_owner_o  (gnt_owner_s),
        .last_grant_o (last_grant_s)
    );

`ifdef RV32I_DMEM_ARB_LOCK_EN
    logic                  lock_q;
    logic [LOCK_CNT_W-1:0] lock_cnt_q;
    logic                  lock_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_d;
    owner_e                unused_last_s;

    assign unused_last_s = last_grant_s;

    // Next lock state: a locked dbg accept extends the lock until the 8th one.
    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        if (accept_s && (gnt_owner_s == DBG)) begin
            if (dbg_req_lock) begin
                if (lock_cnt_q == 3'd7) begin
                    lock_d     = 1'b0;
                    lock_cnt_d = 3'd0;
                end else begin
                    lock_d     = 1'b1;
                    lock_cnt_d = lock_cnt_q + 3'd1;
                end
            end else begin
                lock_d     = 1'b0;
                lock_cnt_d = 3'd0;
            end
        end else begin
            lock_d     = lock_q;
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Lock flag and consecutive-locked-grant counter.
    always_ff @(posedge clk) begin
        if (!RN) begin
            lock_q     <= 1'b0;
            lock_cnt_q <= 3'd0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign lock_s = lock_q;
`else
    logic   unused_lock_s;
    owner_e unused_last_s;

    assign unused_lock_s = dbg_req_lock;
    assign unused_last_s = last_grant_s;
    assign lock_s        = 1'b0;
`endif

    // Route the winning requester's payload toward the command register.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (gnt_owner_s == DBG) begin
            sel_we_s    = dbg_req_we;
            sel_addr_s  = dbg_req_addr;
            sel_wdata_s = dbg_req_wdata;
        end else begin
            sel_we_s    = core_req_we;
            sel_addr_s  = core_req_addr;
            sel_wdata_s = core_req_wdata;
        end
    end

    // Transaction FSM with registered memory strobes, busy and responses.
    always_ff @(posedge clk) begin
        if (!RN) begin
            state_q          <= IDLE;
            owner_q          <= CORE;
            cmd_we_q         <= 1'b0;
            cmd_addr_q       <= '0;
            cmd_wdata_q      <= '0;
            lat_q            <= 3'd0;
            mem_en_q         <= 1'b0;
            mem_we_q         <= 1'b0;
            busy_q           <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            dbg_rsp_valid_q  <= 1'b0;
            core_rsp_rdata_q <= '0;
            dbg_rsp_rdata_q  <= '0;
        end else begin
            core_rsp_valid_q <= 1'b0;
            dbg_rsp_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q     <= ISSUE;
                        owner_q     <= gnt_owner_s;
                        cmd_we_q    <= sel_we_s;
                        cmd_addr_q  <= sel_addr_s;
                        cmd_wdata_q <= sel_wdata_s;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we_s;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (cmd_we_q) begin
                        state_q <= RESP;
                        if (owner_q == DBG) begin
                            dbg_rsp_valid_q <= 1'b1;
                        end else begin
                            core_rsp_valid_q <= 1'b1;
                        end
                    end else begin
                        state_q <= WAIT;
                        lat_q   <= 3'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    if (lat_q == 3'd0) begin
                        state_q <= RESP;
                        if (owner_q == DBG) begin
                            dbg_rsp_valid_q <= 1'b1;
                            dbg_rsp_rdata_q <= mem_rdata;
                        end else begin
                            core_rsp_valid_q <= 1'b1;
                            core_rsp_rdata_q <= mem_rdata;
                        end
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign core_req_ready = accept_s && (gnt_owner_s == CORE);
    assign dbg_req_ready  = accept_s && (gnt_owner_s == DBG);
    assign core_rsp_valid = core_rsp_valid_q;
    assign dbg_rsp_valid  = dbg_rsp_valid_q;
    assign core_rsp_rdata = core_rsp_rdata_q;
    assign dbg_rsp_rdata  = dbg_rsp_rdata_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = cmd_addr_q;
    assign mem_wdata      = cmd_wdata_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// tb_rv32i_dmem_arbiter: directed bench for the DM arbiter with a 32-word
// behavioural memory (read latency 1) and per-scenario checking tasks.
module tb_rv32i_dmem_arbiter;

`ifdef RV32I_DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        RN;
    logic        core_req_valid, core_req_ready, core_req_we;
    logic [4:0]  core_req_addr;
    logic [31:0] core_req_wdata;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_req_lock;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;
    logic        mem_en, mem_we, busy;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          core_rsp_cnt = 0;
    int          dbg_rsp_cnt  = 0;
    int          mem_en_cnt   = 0;
    logic        last_we;
    logic [4:0]  last_addr;
    logic [31:0] last_wdata;
    bit          grants[$];
    int          t6_timeouts;
    bit          dbg_done;

    logic [31:0] mem_model [0:31];

    rv32i_dmem_arbiter dut (
        .clk(clk), .RN(RN),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_we(core_req_we), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
        .core_rsp_rdata(core_rsp_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_we(dbg_req_we), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .dbg_rsp_rdata(dbg_rsp_rdata), .dbg_req_lock(dbg_req_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DM: write on strobe, read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    // Event monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (core_rsp_valid) core_rsp_cnt <= core_rsp_cnt + 1;
        if (dbg_rsp_valid)  dbg_rsp_cnt  <= dbg_rsp_cnt + 1;
        if (mem_en) begin
            mem_en_cnt <= mem_en_cnt + 1;
            last_we    <= mem_we;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
        if (RN && core_req_valid && core_req_ready) grants.push_back(1'b0);
        if (RN && dbg_req_valid && dbg_req_ready)   grants.push_back(1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        RN = 1'b0;
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        dbg_req_lock   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 RN = 1'b1;
    endtask

    // One requester transaction: hold valid until accepted, then wait for rsp.
    task automatic xfer(input bit port, input bit we, input logic [4:0] addr,
                        input logic [31:0] wd, input bit lock,
                        output logic [31:0] rd, output int acc, output int rsp,
                        output bit ok);
        int n;
        ok = 1'b0; rd = 32'h0; acc = -1; rsp = -1;
        if (port == 1'b0) begin
            core_req_we = we; core_req_addr = addr; core_req_wdata = wd;
            core_req_valid = 1'b1;
        end else begin
            dbg_req_we = we; dbg_req_addr = addr; dbg_req_wdata = wd;
            dbg_req_lock = lock; dbg_req_valid = 1'b1;
        end
        n = 0;
        while (acc < 0 && n < 200) begin
            @(negedge clk); n++;
            if ((port == 1'b0) ? core_req_ready : dbg_req_ready) acc = cyc;
        end
        @(posedge clk);
        #1;
        if (port == 1'b0) core_req_valid = 1'b0;
        else              dbg_req_valid  = 1'b0;
        if (acc >= 0) begin
            n = 0;
            while (rsp < 0 && n < 50) begin
                @(negedge clk); n++;
                if (port == 1'b0 && core_rsp_valid) begin rsp = cyc; rd = core_rsp_rdata; end
                if (port == 1'b1 && dbg_rsp_valid)  begin rsp = cyc; rd = dbg_rsp_rdata;  end
            end
            ok = (rsp >= 0);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 5'd1; core_req_wdata = 32'h1;
        dbg_req_valid  = 1'b1; dbg_req_we  = 1'b1; dbg_req_addr  = 5'd2; dbg_req_wdata  = 32'h2;
        dbg_req_lock   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({core_req_ready, dbg_req_ready, busy, mem_en, mem_we, core_rsp_valid, dbg_rsp_valid} !== 7'b0)
            begin failures++; $display("FAIL reset_ctrl: got %b expected 0000000",
                {core_req_ready, dbg_req_ready, busy, mem_en, mem_we, core_rsp_valid, dbg_rsp_valid}); end
        checks++;
        if ({mem_addr, mem_wdata, core_rsp_rdata, dbg_rsp_rdata} !== 101'b0)
            begin failures++; $display("FAIL reset_data: got addr=%0h wdata=%0h crd=%0h drd=%0h expected all 0",
                mem_addr, mem_wdata, core_rsp_rdata, dbg_rsp_rdata); end
        core_req_valid = 1'b0;
        dbg_req_valid  = 1'b0;
        @(posedge clk);
        #1 RN = 1'b1;
    endtask

    task automatic test_core_write();
        logic [31:0] rd; int a, r; bit ok; int en0, d0;
        en0 = mem_en_cnt; d0 = dbg_rsp_cnt;
        xfer(1'b0, 1'b1, 5'd3, 32'h0000_00AB, 1'b0, rd, a, r, ok);
        @(negedge clk);
        checks++;
        if (!ok || (r - a) != 2) begin failures++;
            $display("FAIL wr_latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, r - a); end
        checks++;
        if ((mem_en_cnt - en0) != 1 || last_we !== 1'b1 || last_addr !== 5'd3 || last_wdata !== 32'h0000_00AB)
            begin failures++; $display("FAIL wr_strobe: got en=%0d we=%b addr=%0d wdata=%0h expected en=1 we=1 addr=3 wdata=ab",
                mem_en_cnt - en0, last_we, last_addr, last_wdata); end
        checks++;
        if (dbg_rsp_cnt != d0) begin failures++;
            $display("FAIL wr_dbg_quiet: got %0d dbg rsp expected 0", dbg_rsp_cnt - d0); end
    endtask

    task automatic test_dbg_read();
        logic [31:0] rd; int a, r; bit ok;
        xfer(1'b1, 1'b0, 5'd3, 32'h0, 1'b0, rd, a, r, ok);
        checks++;
        if (!ok || (r - a) != 3) begin failures++;
            $display("FAIL rd_latency: got ok=%0d lat=%0d expected ok=1 lat=3", ok, r - a); end
        checks++;
        if (rd !== 32'h0000_00AB) begin failures++;
            $display("FAIL rd_data: got %0h expected ab", rd); end
    endtask

    task automatic test_round_robin();
        logic [31:0] crd0, crd1, drd0, drd1, rd;
        int ca0, cr0, ca1, cr1, da0, dr0, da1, dr1, a, r, base, c0, d0;
        bit ok, ok0, ok1, ok2, ok3;
        bit exp_own [4];
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0; exp_own[3] = 1'b1;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 1'b1, 5'(10 + i), 32'hC0DE_0000 + 32'(i), 1'b0, rd, a, r, ok);
        apply_reset();
        base = grants.size(); c0 = core_rsp_cnt; d0 = dbg_rsp_cnt;
        fork
            begin
                xfer(1'b0, 1'b0, 5'd10, 32'h0, 1'b0, crd0, ca0, cr0, ok0);
                xfer(1'b0, 1'b0, 5'd12, 32'h0, 1'b0, crd1, ca1, cr1, ok1);
            end
            begin
                xfer(1'b1, 1'b0, 5'd11, 32'h0, 1'b0, drd0, da0, dr0, ok2);
                xfer(1'b1, 1'b0, 5'd13, 32'h0, 1'b0, drd1, da1, dr1, ok3);
            end
        join
        @(negedge clk);
        checks++;
        if (grants.size() - base != 4) begin failures++;
            $display("FAIL rr_count: got %0d grants expected 4", grants.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grants[base + i] !== exp_own[i]) begin failures++;
                    $display("FAIL rr_order[%0d]: got owner %0d expected %0d", i, grants[base + i], exp_own[i]); end
            end
        end
        checks++;
        if (!(ok0 && ok1 && ok2 && ok3) || (dr1 - ca0) != 15) begin failures++;
            $display("FAIL rr_span: got ok=%b span=%0d expected ok=1111 span=15", {ok0, ok1, ok2, ok3}, dr1 - ca0); end
        checks++;
        if (crd0 !== 32'hC0DE_0000 || drd0 !== 32'hC0DE_0001 || crd1 !== 32'hC0DE_0002 || drd1 !== 32'hC0DE_0003)
            begin failures++; $display("FAIL rr_data: got %0h %0h %0h %0h expected c0de0000..c0de0003",
                crd0, drd0, crd1, drd1); end
        checks++;
        if ((core_rsp_cnt - c0) != 2 || (dbg_rsp_cnt - d0) != 2) begin failures++;
            $display("FAIL rr_owner: got core=%0d dbg=%0d rsp expected 2 and 2", core_rsp_cnt - c0, dbg_rsp_cnt - d0); end
    endtask

    task automatic test_same_addr();
        logic [31:0] crd, drd; int ca, cr, da, dr; bit cok, dok;
        apply_reset();
        fork
            xfer(1'b0, 1'b1, 5'd7, 32'h0000_0055, 1'b0, crd, ca, cr, cok);
            xfer(1'b1, 1'b0, 5'd7, 32'h0, 1'b0, drd, da, dr, dok);
        join
        checks++;
        if (!cok || !dok || (da - ca) != 3) begin failures++;
            $display("FAIL raw_order: got ok=%b%b dbg_acc-core_acc=%0d expected ok=11 gap=3", cok, dok, da - ca); end
        checks++;
        if (drd !== 32'h0000_0055) begin failures++;
            $display("FAIL raw_data: got %0h expected 55", drd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; int a, r, n, rb; bit ok, got;
        apply_reset();
        core_req_we = 1'b0; core_req_addr = 5'd3; core_req_valid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin @(negedge clk); n++; if (core_req_ready) got = 1'b1; end
        @(posedge clk);
        #1 core_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!got || busy !== 1'b1 || mem_en !== 1'b0) begin failures++;
            $display("FAIL rst_wait_pre: got acc=%0d busy=%b mem_en=%b expected 1 1 0", got, busy, mem_en); end
        rb = core_rsp_cnt;
        RN = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, core_rsp_valid, mem_en} !== 3'b000) begin failures++;
            $display("FAIL rst_wait_post: got busy/rsp/en=%b expected 000", {busy, core_rsp_valid, mem_en}); end
        @(posedge clk);
        #1 RN = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (core_rsp_cnt != rb) begin failures++;
            $display("FAIL rst_wait_drop: got %0d core rsp expected 0", core_rsp_cnt - rb); end
        xfer(1'b0, 1'b0, 5'd3, 32'h0, 1'b0, rd, a, r, ok);
        checks++;
        if (!ok || (r - a) != 3 || rd !== 32'h0000_00AB) begin failures++;
            $display("FAIL rst_wait_after: got ok=%0d lat=%0d data=%0h expected 1 3 ab", ok, r - a, rd); end
    endtask

    task automatic test_lock();
        int base;
        bit exp_own [10];
        for (int i = 0; i < 10; i++) begin
            if (LOCK_EN) exp_own[i] = (i == 8) ? 1'b0 : 1'b1;
            else         exp_own[i] = (i % 2 == 0) ? 1'b1 : 1'b0;
        end
        apply_reset();
        base = grants.size();
        t6_timeouts = 0;
        dbg_done = 1'b0;
        fork
            begin : dbg_side
                logic [31:0] rd; int a, r; bit ok;
                for (int i = 0; i < 10; i++) begin
                    xfer(1'b1, 1'b0, 5'd10, 32'h0, 1'b1, rd, a, r, ok);
                    if (!ok) t6_timeouts++;
                end
                dbg_done = 1'b1;
                xfer(1'b1, 1'b0, 5'd11, 32'h0, 1'b0, rd, a, r, ok);
                if (!ok) t6_timeouts++;
            end
            begin : core_side
                logic [31:0] rd; int a, r, n; bit ok;
                n = 0;
                while (grants.size() <= base && n < 100) begin @(negedge clk); n++; end
                @(posedge clk);
                #1;
                ok = 1'b1;
                while (!dbg_done && ok) begin
                    xfer(1'b0, 1'b0, 5'd12, 32'h0, 1'b0, rd, a, r, ok);
                    if (!ok) t6_timeouts++;
                end
            end
        join
        @(negedge clk);
        checks++;
        if (t6_timeouts != 0 || grants.size() - base < 10) begin failures++;
            $display("FAIL lock_progress: got timeouts=%0d grants=%0d expected 0 and >=10",
                t6_timeouts, grants.size() - base); end
        else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (grants[base + i] !== exp_own[i]) begin failures++;
                    $display("FAIL lock_order[%0d]: got owner %0d expected %0d", i, grants[base + i], exp_own[i]); end
            end
        end
    endtask

    initial begin
        RN = 1'b0;
        core_req_valid = 1'b0; core_req_we = 1'b0; core_req_addr = 5'd0; core_req_wdata = 32'h0;
        dbg_req_valid  = 1'b0; dbg_req_we  = 1'b0; dbg_req_addr  = 5'd0; dbg_req_wdata  = 32'h0;
        dbg_req_lock   = 1'b0;
        test_reset();
        test_core_write();
        test_dbg_read();
        test_round_robin();
        test_same_addr();
        test_reset_in_wait();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_arbiter.md
Name: rv32i_dmem_arbiter

Overview:
- Arbitrates the single-port 32x32 data memory (DM) between two requesters: the pipeline's MEM stage (core port) and a debug/loader port (dbg port).
- The dbg port preloads and inspects DM while the core runs.
- Round-robin arbitration, valid/ready request handshake, registered memory command, one response pulse per transaction.
- Sits between the core's MEM stage and the DM array; a stall is expressed to the core through core_req_ready low.

Parameters:
- AW, 5, word address width (32-word DM)
- DW, 32, data width
- RD_LAT, 1, DM read latency in cycles from mem_en to mem_rdata valid; legal range 1..4

Ports:
- clk  in  1  system clock
- RN  in  1  reset, active-low, synchronous
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request accepted this cycle
- core_req_we  in  1  1=store (SW), 0=load (LW)
- core_req_addr  in  AW  word address
- core_req_wdata  in  DW  store data
- core_rsp_valid  out  1  one-cycle completion pulse
- core_rsp_rdata  out  DW  load data, valid with core_rsp_valid
- dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_rsp_valid, dbg_rsp_rdata: same as the core_* ports, for the dbg port
- dbg_req_lock  in  1  hold grant for the next dbg request (feature only; ignored otherwise)
- mem_en  out  1  DM access strobe
- mem_we  out  1  DM write enable
- mem_addr  out  AW  DM address
- mem_wdata  out  DW  DM write data
- mem_rdata  in  DW  DM read data
- busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous. On a clk edge with RN=0, every register clears:
  - state=IDLE; last_grant=DBG, so the core wins the first tie
  - all *_ready, *_rsp_valid, mem_en, mem_we and busy outputs =0
  - mem_addr, mem_wdata and both rsp_rdata outputs =0
  - Any in-flight transaction is dropped with no rsp pulse. A DM write already strobed is not undone.
- Handshake:
  - *_req_ready is combinational and is high only in IDLE, for the selected winner.
  - Transfer occurs when valid&&ready are both high on a clk edge.
  - Requesters hold valid and payload stable until accepted.
  - ready never depends on the same cycle's rsp.
- Arbitration in IDLE:
  - Only one valid: that port wins.
  - Both valid: the port != last_grant wins.
  - On accept: last_grant<=winner; the command (we, addr, wdata, owner) is registered.
- FSM: IDLE -> ISSUE -> (write: RESP | read: WAIT) -> RESP -> IDLE.
  - ISSUE: one cycle; mem_en=1, mem_we=cmd_we, mem_addr/mem_wdata from the command register.
  - WAIT: present only for reads; lasts RD_LAT cycles, counted by a lat counter; mem_en=0. At the final WAIT edge, rdata<=mem_rdata.
  - RESP: owner's rsp_valid=1 for exactly one cycle; the other port's rsp_valid stays 0. rsp_rdata holds the captured value until the next read completes; for writes rsp_rdata is unchanged.
- Latency, acceptance to rsp_valid: write = 2 cycles; read = 2+RD_LAT cycles.
- Throughput: one transaction per 3 (write) or 3+RD_LAT (read) cycles. Back-to-back requests are accepted in the IDLE cycle after RESP.
- Requests arriving in non-IDLE states wait; they are neither dropped nor reordered.
- Simultaneous events:
  - A request valid during RESP is arbitrated in the following IDLE.
  - Core and dbg targeting the same address are serialized in grant order; a read after a write returns the new data.
- Widths: address and data are passed unmodified; no wrap or overflow logic, since AW fully covers DM.

Optional Feature:
- Macro: RV32I_DMEM_ARB_LOCK_EN.
- Defined: dbg_req_lock=1 on an accepted dbg transaction sets a lock flag. While the flag is set, IDLE grants only dbg, even if the core is waiting.
  - The flag clears on any accepted dbg transaction with lock=0, or after 8 consecutive locked grants (3-bit counter), so core starvation is bounded.
  - Reset clears both the flag and the counter.
- Undefined: the dbg_req_lock port is still present but ignored; pure round-robin applies.

Decomposition:
- Shared package rv32i_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - owner encoding CORE=1'b0, DBG=1'b1
  - DM_AW=5 and XLEN=32, reused with the core's DM/REG sizing
- One sub-module: rv32i_rr_arb2, a two-input round-robin grant with a last_grant register and a lock override.
- FSM, command registers and response mux stay in the top module.

Test Plan:
1. Reset, then core write addr=3 data=0x0000_00AB → mem_en/mem_we high for 1 cycle with mem_addr=3; core_rsp_valid 2 cycles after acceptance; dbg_rsp_valid stays 0.
2. RD_LAT=1, DM[3]=0xAB: dbg read addr=3 → dbg_rsp_valid 3 cycles after acceptance with dbg_rsp_rdata=0x0000_00AB.
3. Both ports assert read valid continuously from reset → grants alternate core, dbg, core, dbg; four responses in 16 cycles, each owner correct.
4. Core write addr=7 data=0x55, dbg read addr=7 issued the same cycle → core granted first; dbg read returns 0x55.
5. RN driven low during WAIT of a core read → next cycle busy=0, no core_rsp_valid; a new request after RN high completes normally.
6. RV32I_DMEM_ARB_LOCK_EN defined, dbg issues 10 locked reads while the core is valid → first 8 go to dbg, 9th grant goes to core. Without the macro, grants alternate.
